// File: rtl/input_buffer_credit_out_if.sv
// Flit/credit link bundle between the router input buffer and its upstream link and local arbiter.
// master drives flits and pops; slave is the buffer.
interface input_buffer_credit_out_if #(
   parameter int FLIT_WIDTH = 16,
   parameter int PTR_W      = 2
);
   logic [FLIT_WIDTH-1:0] flit_in;
   logic                  valid_in;
   logic [FLIT_WIDTH-1:0] flit_out;
   logic                  valid_out;
   logic                  read_en;
   logic                  credit_out;
   logic                  full;
   logic [PTR_W:0]        occupancy;
   logic                  overflow_err;

   modport master (
      output flit_in, valid_in, read_en,
      input  flit_out, valid_out, credit_out, full, occupancy, overflow_err
   );

   modport slave (
      input  flit_in, valid_in, read_en,
      output flit_out, valid_out, credit_out, full, occupancy, overflow_err
   );
endinterface

// File: rtl/input_buffer_credit_out.sv
// Router input-port flit FIFO that returns one upstream credit per flit drained.
// Optional CREDIT_INIT_BURST_EN: advertise all DEPTH slots with a credit burst after reset.
module input_buffer_credit_out #(
   parameter int FLIT_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int PTR_W      = 2
) (
   input logic                  clk,
   input logic                  reset_n,
   input_buffer_credit_out_if.slave bus
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
`ifdef CREDIT_INIT_BURST_EN
   localparam logic [PTR_W:0]   PEND_RST = DEPTH_C;
`else
   localparam logic [PTR_W:0]   PEND_RST = '0;
`endif

   logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_occ;
   logic [PTR_W:0]        r_pending;
   logic                  r_credit;
   logic                  r_ovf;

   logic                  w_full;
   logic                  w_valid;
   logic                  w_rd;
   logic                  w_wr;
   logic                  w_drop;
   logic [PTR_W:0]        w_occ_nxt;
   logic [PTR_W:0]        w_avail;
   logic                  w_emit;

   assign w_full  = (r_occ == DEPTH_C);
   assign w_valid = (r_occ != '0);
   assign w_rd    = bus.read_en & w_valid;
   // A pop on the same edge frees the slot, so a write at full is still accepted.
   assign w_wr    = bus.valid_in & (~w_full | w_rd);
   assign w_drop  = bus.valid_in & ~w_wr;

   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_wr, w_rd})
         2'b10:   w_occ_nxt = r_occ + CNT_ONE;
         2'b01:   w_occ_nxt = r_occ - CNT_ONE;
         default: w_occ_nxt = r_occ;
      endcase
   end

   // Credits owed including this cycle's pop; one is emitted per cycle while any are owed.
   assign w_avail = r_pending + (PTR_W+1)'(w_rd);
   assign w_emit  = (w_avail != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_occ     <= '0;
         r_pending <= PEND_RST;
         r_credit  <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_occ     <= w_occ_nxt;
         r_pending <= w_avail - (PTR_W+1)'(w_emit);
         r_credit  <= w_emit;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   // Storage carries no reset; contents are only observed while valid_out is high.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= bus.flit_in;
   end

   assign bus.flit_out     = r_mem[r_rd_ptr];
   assign bus.valid_out    = w_valid;
   assign bus.full         = w_full;
   assign bus.occupancy    = r_occ;
   assign bus.credit_out   = r_credit;
   assign bus.overflow_err = r_ovf;

endmodule

// File: tb/tb_input_buffer_credit_out.sv
// Self-checking bench for input_buffer_credit_out: directed vector table, reset/credit-burst
// sequences and randomized traffic against a queue-based reference model.
module tb_input_buffer_credit_out;
   localparam int FW    = 16;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
`ifdef CREDIT_INIT_BURST_EN
   localparam int BURST = DEPTH;
`else
   localparam int BURST = 0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   input_buffer_credit_out_if #(.FLIT_WIDTH(FW), .PTR_W(PTR_W)) bus();

   input_buffer_credit_out #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: flit queue plus running totals of credits owed and credits already shown.
   logic [FW-1:0] mq[$];
   bit            m_ovf;
   int            m_owed;
   int            m_emit;
   int            credit_seen;

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_owed = BURST;
      m_emit = 0;
   endtask

   // Called at a negedge: drive one cycle of inputs, then check outputs at the next negedge.
   task automatic step(input bit vin, input logic [FW-1:0] din, input bit ren);
      bit pop, push, exp_cr;
      bus.valid_in = vin;
      bus.flit_in  = din;
      bus.read_en  = ren;
      pop  = ren && (mq.size() > 0);
      push = vin && ((mq.size() < DEPTH) || pop);
      if (vin && !push) m_ovf = 1'b1;
      if (pop) begin
         void'(mq.pop_front());
         m_owed++;
      end
      if (push) mq.push_back(din);
      exp_cr = (m_owed > m_emit);
      if (exp_cr) m_emit++;
      @(negedge clk);
      check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
      check("valid_out", 32'(bus.valid_out), 32'(mq.size() != 0));
      check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      check("credit_out", 32'(bus.credit_out), 32'(exp_cr));
      check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
      if (mq.size() > 0) check("flit_out", 32'(bus.flit_out), 32'(mq[0]));
      if (bus.credit_out === 1'b1) credit_seen++;
   endtask

   typedef struct {
      bit            vin;
      logic [FW-1:0] din;
      bit            ren;
      int            occ;
      bit            full;
      bit            vout;
      logic [FW-1:0] head;
      bit            cr;
      bit            ovf;
   } vec_t;

   vec_t tbl[21];

   initial begin
      // fill / drain, full with simultaneous read+write, overflow, read on empty
      tbl[0]  = '{1, 16'hA001, 0, 1, 0, 1, 16'hA001, 0, 0};
      tbl[1]  = '{1, 16'hA002, 0, 2, 0, 1, 16'hA001, 0, 0};
      tbl[2]  = '{1, 16'hA003, 0, 3, 0, 1, 16'hA001, 0, 0};
      tbl[3]  = '{1, 16'hA004, 0, 4, 1, 1, 16'hA001, 0, 0};
      tbl[4]  = '{0, 16'h0000, 1, 3, 0, 1, 16'hA002, 1, 0};
      tbl[5]  = '{0, 16'h0000, 1, 2, 0, 1, 16'hA003, 1, 0};
      tbl[6]  = '{0, 16'h0000, 1, 1, 0, 1, 16'hA004, 1, 0};
      tbl[7]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0};
      tbl[8]  = '{0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0};
      tbl[9]  = '{1, 16'hB001, 0, 1, 0, 1, 16'hB001, 0, 0};
      tbl[10] = '{1, 16'hB002, 0, 2, 0, 1, 16'hB001, 0, 0};
      tbl[11] = '{1, 16'hB003, 0, 3, 0, 1, 16'hB001, 0, 0};
      tbl[12] = '{1, 16'hB004, 0, 4, 1, 1, 16'hB001, 0, 0};
      tbl[13] = '{1, 16'hB005, 1, 4, 1, 1, 16'hB002, 1, 0};
      tbl[14] = '{0, 16'h0000, 0, 4, 1, 1, 16'hB002, 0, 0};
      tbl[15] = '{1, 16'hC006, 0, 4, 1, 1, 16'hB002, 0, 1};
      tbl[16] = '{0, 16'h0000, 1, 3, 0, 1, 16'hB003, 1, 1};
      tbl[17] = '{0, 16'h0000, 1, 2, 0, 1, 16'hB004, 1, 1};
      tbl[18] = '{0, 16'h0000, 1, 1, 0, 1, 16'hB005, 1, 1};
      tbl[19] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1};
      tbl[20] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};

      reset_n      = 1'b0;
      bus.valid_in = 1'b0;
      bus.flit_in  = '0;
      bus.read_en  = 1'b0;
      credit_seen  = 0;
      model_reset();

      repeat (2) @(negedge clk);
      check("rst_occupancy", 32'(bus.occupancy), 32'd0);
      check("rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_credit_out", 32'(bus.credit_out), 32'd0);
      check("rst_overflow_err", 32'(bus.overflow_err), 32'd0);
      reset_n = 1'b1;

      // let any post-reset credit burst drain (model-checked every cycle)
      repeat (DEPTH + 2) step(1'b0, '0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         bus.valid_in = tbl[i].vin;
         bus.flit_in  = tbl[i].din;
         bus.read_en  = tbl[i].ren;
         @(negedge clk);
         check($sformatf("tbl%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].occ));
         check($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
         check($sformatf("tbl%0d_valid_out", i), 32'(bus.valid_out), 32'(tbl[i].vout));
         check($sformatf("tbl%0d_credit_out", i), 32'(bus.credit_out), 32'(tbl[i].cr));
         check($sformatf("tbl%0d_overflow_err", i), 32'(bus.overflow_err), 32'(tbl[i].ovf));
         if (tbl[i].vout) check($sformatf("tbl%0d_flit_out", i), 32'(bus.flit_out), 32'(tbl[i].head));
      end

      // async reset mid-traffic: occupancy, credit and sticky error all set when reset hits
      bus.valid_in = 1'b1; bus.flit_in = 16'hD001; bus.read_en = 1'b0;
      @(negedge clk);
      bus.flit_in = 16'hD002;
      @(negedge clk);
      bus.valid_in = 1'b0; bus.read_en = 1'b1;
      @(negedge clk);
      bus.read_en = 1'b0;
      check("pre_rst_credit_out", 32'(bus.credit_out), 32'd1);
      check("pre_rst_occupancy", 32'(bus.occupancy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_occupancy", 32'(bus.occupancy), 32'd0);
      check("async_rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("async_rst_full", 32'(bus.full), 32'd0);
      check("async_rst_credit_out", 32'(bus.credit_out), 32'd0);
      check("async_rst_overflow_err", 32'(bus.overflow_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;

      // write in the first cycle after release, pop in the second: burst (if any) plus one credit
      credit_seen = 0;
      step(1'b1, 16'hE001, 1'b0);
      step(1'b0, '0, 1'b1);
      repeat (8) step(1'b0, '0, 1'b0);
      check("credit_pulses_after_reset", 32'(credit_seen), 32'(BURST + 1));

      // interleaved write/pop pairs wrap both pointers; then reads on empty
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'hF000 + 16'(i), 1'b0);
         step(1'b0, '0, 1'b1);
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // randomized traffic: write-heavy phase pushes to full/overflow, read-heavy phase drains
      for (int i = 0; i < 400; i++) begin
         bit vin, ren;
         if (i < 200) begin
            vin = ($urandom_range(3) != 0);
            ren = ($urandom_range(3) == 0);
         end else begin
            vin = ($urandom_range(1) != 0);
            ren = ($urandom_range(3) != 0);
         end
         step(vin, 16'($urandom), ren);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
